// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle for alu_issue_ctrl.
// master = requester side, slave = the issue controller.
interface alu_issue_ctrl_if #(
  parameter int ALU_OPERATION_WIDTH = 5
);
  logic                           req_valid;
  logic                           req_ready;
  logic [ALU_OPERATION_WIDTH-1:0] req_op;
  logic [31:0]                    req_a;
  logic [31:0]                    req_b;
  logic [4:0]                     req_rd;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [31:0]                    rsp_data;
  logic [4:0]                     rsp_rd;
  logic                           rsp_illegal;
  logic                           fault;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_rd, rsp_illegal, fault
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_rd, rsp_illegal, fault
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: latches one request, drives the ALU, returns a response.
// Define ALU_ISSUE_WATCHDOG_EN to add the WAIT-state timeout watchdog.
module alu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES      = 64,
  parameter int ALU_OPERATION_WIDTH = 5
) (
  input  logic                           clock,
  input  logic                           reset_n,
  alu_issue_ctrl_if.slave                bus,
  output logic [ALU_OPERATION_WIDTH-1:0] alu_operation,
  output logic [31:0]                    alu_in1,
  output logic [31:0]                    alu_in2,
  output logic                           alu_clock_enable,
  input  logic                           alu_op_valid,
  input  logic                           alu_op_sync,
  input  logic                           alu_result_ready,
  input  logic [31:0]                    alu_out_async,
  input  logic [31:0]                    alu_out_sync
);
  localparam int OPW = ALU_OPERATION_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    WAIT,
    RESP,
    FAULT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OPW-1:0] op_q;
  logic [31:0]    a_q;
  logic [31:0]    b_q;
  logic [4:0]     rd_q;

  logic [31:0]    data_q;
  logic [4:0]     rsp_rd_q;
  logic           ill_q;
  logic           fault_q;

  logic           ready;
  logic           en;
  logic           accept;
  logic           capture;
  logic           cap_ill;
  logic [31:0]    cap_data;
  logic           wd_clear;
  logic           wd_inc;
  logic           wd_expire;
  logic           fault_set;

  logic           illegal_op;
  logic           sync_op;
  logic           async_op;

  assign illegal_op = !alu_op_valid;
  assign sync_op    = alu_op_valid && alu_op_sync;
  assign async_op   = alu_op_valid && !alu_op_sync;

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    en        = 1'b0;
    capture   = 1'b0;
    cap_ill   = 1'b0;
    cap_data  = '0;
    wd_clear  = 1'b0;
    wd_inc    = 1'b0;
    fault_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (1'b1)
          illegal_op: begin
            capture = 1'b1;
            cap_ill = 1'b1;
            state_d = RESP;
          end
          sync_op: begin
            en       = 1'b1;
            wd_clear = 1'b1;
            state_d  = WAIT;
          end
          async_op: begin
            capture  = 1'b1;
            cap_data = alu_out_async;
            state_d  = RESP;
          end
        endcase
      end
      WAIT: begin
        // Ready seen in EXEC is stale; the issue edge clears it.
        en = !alu_result_ready;
        if (alu_result_ready) begin
          capture  = 1'b1;
          cap_data = alu_out_sync;
          state_d  = RESP;
        end else if (wd_expire) begin
          capture   = 1'b1;
          cap_ill   = 1'b1;
          fault_set = 1'b1;
          state_d   = RESP;
        end else begin
          wd_inc = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          if (fault_q) begin
            state_d = FAULT;
          end else begin
            ready   = 1'b1;
            state_d = bus.req_valid ? EXEC : IDLE;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept = ready && bus.req_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
    end else if (accept) begin
      op_q <= bus.req_op;
      a_q  <= bus.req_a;
      b_q  <= bus.req_b;
      rd_q <= bus.req_rd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      rsp_rd_q <= '0;
      ill_q    <= 1'b0;
    end else if (capture) begin
      data_q   <= cap_data;
      rsp_rd_q <= rd_q;
      ill_q    <= cap_ill;
    end
  end

`ifdef ALU_ISSUE_WATCHDOG_EN
  localparam int WDW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST =
    WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (wd_clear) begin
      wd_q <= '0;
    end else if (wd_inc) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // Sticky until reset; steers RESP into FAULT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end

  assign wd_expire = (wd_q == WD_LAST);
`else
  logic unused_wd;

  assign fault_q   = 1'b0;
  assign wd_expire = 1'b0;
  assign unused_wd =
    ^{wd_clear, wd_inc, fault_set, TIMEOUT_CYCLES[0]};
`endif

  assign bus.req_ready   = ready;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_data    = data_q;
  assign bus.rsp_rd      = rsp_rd_q;
  assign bus.rsp_illegal = ill_q;
  assign bus.fault       = fault_q;

  assign alu_operation    = op_q;
  assign alu_in1          = a_q;
  assign alu_in2          = b_q;
  assign alu_clock_enable = en;
endmodule
